// File: rtl/scene_scheduler.sv
// Scene playlist sequencer: walks a fixed 4-entry playlist of pattern/overlay/duration records.
// Define SCENE_FADE_EN to build the fade-out/fade-in sequencing; without it scenes cut directly.
module scene_scheduler #(
    parameter int unsigned FADE_STEP_FRAMES = 4,
    parameter int unsigned PLAYLIST_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       next_frame,
    input  logic       skip,
    input  logic       hold,
    output logic [1:0] pattern_select,
    output logic [1:0] overlay_en,
    output logic [1:0] fade_level,
    output logic [1:0] scene_index,
    output logic       scene_start
);

    localparam logic [1:0] StPlay   = 2'd0;
    localparam logic [1:0] StSwitch = 2'd2;
`ifdef SCENE_FADE_EN
    localparam logic [1:0] StFadeOut   = 2'd1;
    localparam logic [1:0] StFadeIn    = 2'd3;
    localparam logic [1:0] StLeavePlay = StFadeOut;
    localparam logic [1:0] StAfterLoad = StFadeIn;
    localparam logic [3:0] StepLast    = 4'(FADE_STEP_FRAMES - 1);
`else
    localparam logic [1:0] StLeavePlay = StSwitch;
    localparam logic [1:0] StAfterLoad = StPlay;
`endif

    localparam logic [1:0] LastIndex = 2'(PLAYLIST_LEN - 1);

    logic       skip_meta_q, skip_meta_d;
    logic       skip_sync_q, skip_sync_d;
    logic       skip_prev_q, skip_prev_d;
    logic [1:0] skip_fill_q, skip_fill_d;
    logic       skip_pulse;

    logic [1:0] state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] scene_index_q, scene_index_d;
    logic [1:0] pattern_q, pattern_d;
    logic [1:0] overlay_q, overlay_d;
    logic       scene_start_q, scene_start_d;

    logic       frame_tick;
    logic [1:0] next_index;
    logic [1:0] next_pattern;
    logic [1:0] next_overlay;
    logic [7:0] next_duration;

`ifdef SCENE_FADE_EN
    logic [1:0] fade_q, fade_d;
    logic [3:0] step_q, step_d;
`endif

    assign frame_tick = next_frame & ~hold;

    always_comb begin
        skip_meta_d = skip;
        skip_sync_d = skip_meta_q;
        skip_prev_d = skip_sync_q;
        skip_fill_d = (skip_fill_q == 2'd3) ? 2'd3 : skip_fill_q + 2'd1;
    end

    // Edges are ignored until the detector holds a genuine post-reset sample, so a button
    // held through reset release cannot look like a fresh press.
    assign skip_pulse = skip_sync_q & ~skip_prev_q & (skip_fill_q == 2'd3);

    always_comb begin
        next_index = (scene_index_q == LastIndex) ? 2'd0 : scene_index_q + 2'd1;
        unique case (next_index)
            2'd0: begin
                next_pattern  = 2'd0;
                next_overlay  = 2'b11;
                next_duration = 8'd240;
            end
            2'd1: begin
                next_pattern  = 2'd1;
                next_overlay  = 2'b11;
                next_duration = 8'd240;
            end
            2'd2: begin
                next_pattern  = 2'd0;
                next_overlay  = 2'b00;
                next_duration = 8'd120;
            end
            default: begin
                next_pattern  = 2'd1;
                next_overlay  = 2'b01;
                next_duration = 8'd60;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        scene_index_d = scene_index_q;
        pattern_d     = pattern_q;
        overlay_d     = overlay_q;
        scene_start_d = 1'b0;
`ifdef SCENE_FADE_EN
        fade_d        = fade_q;
        step_d        = step_q;
`endif
        case (state_q)
            StPlay: begin
                // A skip coinciding with expiry still yields a single transition.
                if (skip_pulse || (frame_tick && frame_cnt_q == 8'd1)) begin
                    state_d = StLeavePlay;
                end else if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q - 8'd1;
                end
            end
            StSwitch: begin
                scene_index_d = next_index;
                pattern_d     = next_pattern;
                overlay_d     = next_overlay;
                frame_cnt_d   = next_duration;
                scene_start_d = 1'b1;
                state_d       = StAfterLoad;
            end
`ifdef SCENE_FADE_EN
            StFadeOut: begin
                if (frame_tick) begin
                    if (step_q == StepLast) begin
                        step_d = 4'd0;
                        if (fade_q != 2'd0) begin
                            fade_d = fade_q - 2'd1;
                        end
                        if (fade_q <= 2'd1) begin
                            state_d = StSwitch;
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            StFadeIn: begin
                if (frame_tick) begin
                    if (step_q == StepLast) begin
                        step_d = 4'd0;
                        if (fade_q != 2'd3) begin
                            fade_d = fade_q + 2'd1;
                        end
                        if (fade_q >= 2'd2) begin
                            state_d = StPlay;
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
`endif
            default: state_d = StPlay;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_meta_q   <= 1'b0;
            skip_sync_q   <= 1'b0;
            skip_prev_q   <= 1'b0;
            skip_fill_q   <= 2'd0;
            state_q       <= StPlay;
            frame_cnt_q   <= 8'd240;
            scene_index_q <= 2'd0;
            pattern_q     <= 2'd0;
            overlay_q     <= 2'b11;
            scene_start_q <= 1'b0;
        end else begin
            skip_meta_q   <= skip_meta_d;
            skip_sync_q   <= skip_sync_d;
            skip_prev_q   <= skip_prev_d;
            skip_fill_q   <= skip_fill_d;
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            scene_index_q <= scene_index_d;
            pattern_q     <= pattern_d;
            overlay_q     <= overlay_d;
            scene_start_q <= scene_start_d;
        end
    end

`ifdef SCENE_FADE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_q <= 2'd3;
            step_q <= 4'd0;
        end else begin
            fade_q <= fade_d;
            step_q <= step_d;
        end
    end

    assign fade_level = fade_q;
`else
    assign fade_level = 2'd3;
`endif

    assign pattern_select = pattern_q;
    assign overlay_en     = overlay_q;
    assign scene_index    = scene_index_q;
    assign scene_start    = scene_start_q;

endmodule

// File: tb/tb_scene_scheduler.sv
// Bench for scene_scheduler: constant-vector table, directed corner sequences and a
// randomized run checked every cycle against a playlist-level reference model.
module tb_scene_scheduler;

    localparam int unsigned F = 4;
`ifdef SCENE_FADE_EN
    localparam bit FadeOn = 1'b1;
`else
    localparam bit FadeOn = 1'b0;
`endif

    localparam int PhPlay   = 0;
    localparam int PhOut    = 1;
    localparam int PhSwitch = 2;
    localparam int PhIn     = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       next_frame = 1'b0;
    logic       skip = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] pattern_select;
    logic [1:0] overlay_en;
    logic [1:0] fade_level;
    logic [1:0] scene_index;
    logic       scene_start;

    scene_scheduler #(
        .FADE_STEP_FRAMES(F),
        .PLAYLIST_LEN    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_frame    (next_frame),
        .skip          (skip),
        .hold          (hold),
        .pattern_select(pattern_select),
        .overlay_en    (overlay_en),
        .fade_level    (fade_level),
        .scene_index   (scene_index),
        .scene_start   (scene_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned pulses;
        int unsigned idle;
        bit          hold;
        logic [1:0]  scene;
        logic [1:0]  pat;
        logic [1:0]  ovl;
        logic [1:0]  fade;
        logic        start;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          starts_seen = 0;

    // Reference model state: which entry plays, frames left, fade progress in pulses.
    int m_scene;
    int m_left;
    int m_phase;
    int m_fp;
    bit m_start;
    int m_edges;
    bit skip_hist[$];

    function automatic int dur_of(input int s);
        case (s)
            0, 1:    return 240;
            2:       return 120;
            default: return 60;
        endcase
    endfunction

    function automatic logic [1:0] pat_of(input int s);
        return (s == 1 || s == 3) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] ovl_of(input int s);
        if (s < 2) return 2'b11;
        return (s == 2) ? 2'b00 : 2'b01;
    endfunction

    function automatic logic [8:0] dut_vec();
        return {scene_index, pattern_select, overlay_en, fade_level, scene_start};
    endfunction

    function automatic logic [8:0] model_vec();
        logic [1:0] f;
        case (m_phase)
            PhOut:    f = 2'(3 - m_fp / int'(F));
            PhSwitch: f = FadeOn ? 2'd0 : 2'd3;
            PhIn:     f = 2'(m_fp / int'(F));
            default:  f = 2'd3;
        endcase
        return {2'(m_scene), pat_of(m_scene), ovl_of(m_scene), f, m_start};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {scene,pat,ovl,fade,start}=%b required %b @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scene = 0;
        m_left  = 240;
        m_phase = PhPlay;
        m_fp    = 0;
        m_start = 1'b0;
        m_edges = 0;
        skip_hist.delete();
    endtask

    task automatic model_edge(input bit nf, input bit hd, input bit sk);
        bit tick;
        bit pulse;
        int sz;
        tick = nf && !hd;
        m_edges++;
        skip_hist.push_back(sk);
        sz = skip_hist.size();
        // A press is seen two clocks late, and only once a full sample history exists.
        pulse = (m_edges >= 4) && skip_hist[sz - 3] && !skip_hist[sz - 4];
        if (sz > 4) void'(skip_hist.pop_front());
        m_start = 1'b0;
        case (m_phase)
            PhPlay: begin
                if (pulse || (tick && m_left == 1)) begin
                    m_phase = FadeOn ? PhOut : PhSwitch;
                    m_fp    = 0;
                end else if (tick) begin
                    m_left--;
                end
            end
            PhOut: begin
                if (tick) m_fp++;
                if (m_fp == 3 * int'(F)) m_phase = PhSwitch;
            end
            PhSwitch: begin
                m_scene = (m_scene + 1) % 4;
                m_left  = dur_of(m_scene);
                m_phase = FadeOn ? PhIn : PhPlay;
                m_fp    = 0;
                m_start = 1'b1;
            end
            default: begin
                if (tick) m_fp++;
                if (m_fp == 3 * int'(F)) begin
                    m_phase = PhPlay;
                    m_fp    = 0;
                end
            end
        endcase
    endtask

    // Called at posedge+1: drive, take one edge, compare against the model.
    task automatic step(input bit nf, input bit hd, input bit sk);
        next_frame = nf;
        hold       = hd;
        skip       = sk;
        @(posedge clk);
        model_edge(nf, hd, sk);
        #1;
        check("model", dut_vec(), model_vec());
        if (scene_start === 1'b1) starts_seen++;
    endtask

    // Asserts reset off-edge, checks the outputs respond at once, releases after an edge.
    task automatic do_reset(input bit sk);
        next_frame = 1'b0;
        hold       = 1'b0;
        skip       = sk;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset values", dut_vec(), {2'd0, 2'd0, 2'b11, 2'd3, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        int   base;
        bit   sk;

        @(posedge clk);
        #1;

        // Constant-expectation table from reset.
        do_reset(1'b0);
`ifdef SCENE_FADE_EN
        tbl.push_back('{0,   0, 1'b0, 2'd0, 2'd0, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{240, 0, 1'b0, 2'd0, 2'd0, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{4,   0, 1'b0, 2'd0, 2'd0, 2'b11, 2'd2, 1'b0});
        tbl.push_back('{4,   0, 1'b0, 2'd0, 2'd0, 2'b11, 2'd1, 1'b0});
        tbl.push_back('{4,   0, 1'b0, 2'd0, 2'd0, 2'b11, 2'd0, 1'b0});
        tbl.push_back('{0,   1, 1'b0, 2'd1, 2'd1, 2'b11, 2'd0, 1'b1});
        tbl.push_back('{4,   0, 1'b0, 2'd1, 2'd1, 2'b11, 2'd1, 1'b0});
        tbl.push_back('{4,   0, 1'b0, 2'd1, 2'd1, 2'b11, 2'd2, 1'b0});
        tbl.push_back('{4,   0, 1'b0, 2'd1, 2'd1, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{100, 0, 1'b1, 2'd1, 2'd1, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{239, 0, 1'b0, 2'd1, 2'd1, 2'b11, 2'd3, 1'b0});
`else
        tbl.push_back('{0,   0, 1'b0, 2'd0, 2'd0, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{239, 0, 1'b0, 2'd0, 2'd0, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{1,   0, 1'b0, 2'd0, 2'd0, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{0,   1, 1'b0, 2'd1, 2'd1, 2'b11, 2'd3, 1'b1});
        tbl.push_back('{0,   1, 1'b0, 2'd1, 2'd1, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{100, 0, 1'b1, 2'd1, 2'd1, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{239, 0, 1'b0, 2'd1, 2'd1, 2'b11, 2'd3, 1'b0});
        tbl.push_back('{1,   1, 1'b0, 2'd2, 2'd0, 2'b00, 2'd3, 1'b1});
        tbl.push_back('{120, 1, 1'b0, 2'd3, 2'd1, 2'b01, 2'd3, 1'b1});
        tbl.push_back('{60,  1, 1'b0, 2'd0, 2'd0, 2'b11, 2'd3, 1'b1});
        tbl.push_back('{0,   1, 1'b0, 2'd0, 2'd0, 2'b11, 2'd3, 1'b0});
`endif
        foreach (tbl[i]) begin
            for (int p = 0; p < int'(tbl[i].pulses); p++) step(1'b1, tbl[i].hold, 1'b0);
            for (int p = 0; p < int'(tbl[i].idle); p++) step(1'b0, 1'b0, 1'b0);
            check($sformatf("table[%0d]", i), dut_vec(),
                  {tbl[i].scene, tbl[i].pat, tbl[i].ovl, tbl[i].fade, tbl[i].start});
        end

        // Skip held high through reset release must not advance.
        do_reset(1'b1);
        base = starts_seen;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        check_int("skip through reset starts", starts_seen - base, 0);

        // Long-held skip: one advance, then scene 1 runs its full length.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        base = starts_seen;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < (FadeOn ? 12 : 0); i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < (FadeOn ? 1 : 0); i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < (FadeOn ? 12 : 0); i++) step(1'b1, 1'b0, 1'b1);
        for (int i = (FadeOn ? 29 : 4); i < 500; i++) step(1'b0, 1'b0, 1'b1);
        check_int("held skip advance count", starts_seen - base, 1);
        check("after held skip", dut_vec(), {2'd1, 2'd1, 2'b11, 2'd3, 1'b0});
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 239; i++) step(1'b1, 1'b0, 1'b0);
        check("scene1 frame 239", dut_vec(), {2'd1, 2'd1, 2'b11, 2'd3, 1'b0});
        for (int i = 0; i < (FadeOn ? 13 : 1); i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("scene1 expiry", dut_vec(), {2'd2, 2'd0, 2'b00, FadeOn ? 2'd0 : 2'd3, 1'b1});

        // Skip while hold is high still leaves PLAY.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < (FadeOn ? 12 : 0); i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("skip during hold", dut_vec(), {2'd1, 2'd1, 2'b11, FadeOn ? 2'd0 : 2'd3, 1'b1});

        // Reset in the middle of a transition abandons it silently.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < (FadeOn ? 8 : 0); i++) step(1'b1, 1'b0, 1'b0);
        check("mid transition", dut_vec(), {2'd0, 2'd0, 2'b11, FadeOn ? 2'd1 : 2'd3, 1'b0});
        base = starts_seen;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        check_int("no start after abort", starts_seen - base, 0);

        // Randomized run against the model.
        do_reset(1'b0);
        sk = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 39) == 0) sk = !sk;
            if ($urandom_range(0, 4999) == 0) do_reset(sk);
            step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, sk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scene_scheduler.md
SCENE_SCHEDULER -- requirements
Module: scene_scheduler

Interface
REQ-001 Parameter FADE_STEP_FRAMES, default 4: next_frame pulses per fade_level step; legal range 1..15.
REQ-002 Parameter PLAYLIST_LEN, default 4: playlist entries; fixed at 4 in this revision.
REQ-003 clk  input  1  pixel clock (25.2 MHz); the block's only clock.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 next_frame  input  1  one-clk frame-advance pulse from speed_controller.
REQ-006 skip  input  1  asynchronous user button; a rising edge requests the next scene.
REQ-007 hold  input  1  level; freezes all frame-based counting while high.
REQ-008 pattern_select  output  2  pattern id to pattern_selector (0 checkerboard, 1 radient).
REQ-009 overlay_en  output  2  bit0 enables the emblem layer, bit1 enables the text layer.
REQ-010 fade_level  output  2  brightness; 3 = full, 0 = black.
REQ-011 scene_index  output  2  current playlist entry.
REQ-012 scene_start  output  1  one-clk pulse when a new scene is loaded.

Function
REQ-013 The playlist SHALL be a fixed table with fields {pattern, overlay_en, duration}: 0={0,2'b11,240}, 1={1,2'b11,240}, 2={0,2'b00,120}, 3={1,2'b01,60}.
REQ-014 All outputs SHALL be registered; any input event SHALL become visible on the outputs on the following clk edge.
REQ-015 The block SHALL pass skip through a 2-flop synchronizer followed by a rising-edge detector; the result is skip_pulse, one clk wide per press.
REQ-016 The FSM SHALL have the states PLAY, FADE_OUT, SWITCH and FADE_IN.
REQ-017 PLAY: the frame counter SHALL decrement on each next_frame while hold=0; when next_frame arrives with the counter at 1, the FSM SHALL go to FADE_OUT.
REQ-018 PLAY: skip_pulse SHALL force the transition to FADE_OUT on the next edge, regardless of hold and of the counter value.
REQ-019 skip_pulse and expiry in the same cycle SHALL cause exactly one transition; skip_pulse outside PLAY SHALL be discarded.
REQ-020 FADE_OUT: a step counter SHALL count next_frame pulses while hold=0; every FADE_STEP_FRAMES pulses, fade_level SHALL decrement; on reaching 0 the FSM SHALL go to SWITCH.
REQ-021 SWITCH SHALL last exactly one clk: scene_index advances modulo 4 (3 wraps to 0), and pattern_select, overlay_en and the frame counter load from the new entry; scene_start SHALL be 1 in the following cycle only.
REQ-022 FADE_IN: fade_level SHALL increment every FADE_STEP_FRAMES counted pulses; on reaching 3 the FSM SHALL go to PLAY, and the step counter SHALL clear.
REQ-023 Each fade direction SHALL take 3*FADE_STEP_FRAMES pulses (12 at the default).
REQ-024 pattern_select, overlay_en and scene_index SHALL change only in SWITCH.
REQ-025 fade_level SHALL never wrap below 0 or above 3.

Reset
REQ-026 Asserting rst_n low SHALL immediately force: state PLAY, scene_index 0, pattern_select 0, overlay_en 2'b11, fade_level 3, scene_start 0, frame counter 240, step counter 0, and synchronizer flops 0.
REQ-027 Reset asserted mid-fade or mid-SWITCH SHALL abandon the transition without emitting scene_start.
REQ-028 A skip held high through reset release SHALL NOT produce a skip_pulse.

Configuration
REQ-029 With SCENE_FADE_EN defined, the fades SHALL follow REQ-020 to REQ-023.
REQ-030 With SCENE_FADE_EN undefined, PLAY SHALL go directly to SWITCH and SWITCH SHALL go directly to PLAY; fade_level SHALL be constant 3, and the fade logic SHALL be absent.

Verification
REQ-031 No fade, reset, then 240 next_frame pulses -> SWITCH; then scene_index=1, pattern_select=1, overlay_en=2'b11, and scene_start high for exactly 1 clk.
REQ-032 Fade on, scene 0 expiry -> fade_level reads 2, 1, 0 after 4, 8, 12 pulses; SWITCH; then 1, 2, 3 after a further 4, 8, 12 pulses; then PLAY.
REQ-033 skip pressed at frame 10 of scene 0 and held high for 500 pulses -> exactly one advance to scene 1; scene 1 then plays its full 240 frames.
REQ-034 hold=1 for 100 pulses in PLAY -> counter unchanged; skip during hold -> FADE_OUT the next clk.
REQ-035 Scene 3 (60 frames, overlay_en=01) expires -> scene_index wraps to 0 and overlay_en returns to 11.
REQ-036 rst_n pulsed low at fade_level=1 in FADE_OUT -> all outputs equal the REQ-026 values within the same cycle, with no scene_start.
